bblock_seq: RTL and testbench
=============================

# bblock_seq

Sequencer that drives one combinational B-block cell through a programmed list of control codes and collects the cell's output bit for each step. It holds a small program memory of `{x, g5..g1}` codes and plays them out one per clock on `start`. It captures the returned `A` bit into a result vector and signals completion with a `done` pulse. It sits between the host/test logic and the B-block datapath, replacing static tie-offs of `g1..g5`/`x`.

## Interface
- `DEPTH`, default 8: number of program slots (power of two, 2..32).
- `AW`, default 3: address width, equal to log2(DEPTH).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `prog_we`  in  1  program write strobe.
- `prog_addr`  in  AW  program slot index.
- `prog_data`  in  6  code: bit5=`x`, bit4=`g5`, bit3=`g4`, bit2=`g3`, bit1=`g2`, bit0=`g1`.
- `len`  in  AW+1  steps to run, 1..DEPTH; sampled on accepted `start`.
- `start`  in  1  run request (level-sampled).
- `busy`  out  1  high while running.
- `done`  out  1  one-cycle completion pulse.
- `g_out`  out  5  to B-block `{g5,g4,g3,g2,g1}`.
- `x_out`  out  1  to B-block `x`.
- `a_in`  in  1  B-block output `A` (combinational from `g_out`/`x_out`).
- `result`  out  DEPTH  captured `A` per step; bit i is step i.
- `mismatch`  out  1  sticky check flag (see Configuration).

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `busy`=0; `g_out`=0 and `x_out`=0.
  - `prog_we` writes `prog_data` to slot `prog_addr`.
  - `start`=1 with `len`≠0 → RUN. On that edge: `step`←0, `result`←0, `mismatch`←0, and `len` is latched as `n`.
  - `len`=0 → `start` ignored. `len`>DEPTH → clamped to DEPTH.
- **RUN**
  - `busy`=1.
  - `g_out`/`x_out` are registered and show slot `step` for the whole cycle.
  - At the end of the cycle, `result[step]`←`a_in` and `step`←`step`+1.
  - After step `n`−1 is captured → DONE.
  - `prog_we` is dropped (no write) and `start` is ignored.
- **DONE**
  - `done`=1 for exactly this cycle; `busy`=0; `g_out`/`x_out`=0.
  - `start` is ignored.
  - Next state is always IDLE.
- `result` holds its value until the next accepted `start`.
- Simultaneous `prog_we` and `start` in IDLE: the write completes on the same edge and is visible if that slot is run.
- Reset, including mid-RUN:
  - State → IDLE.
  - `busy`, `done`, `g_out`, `x_out`, `result`, `mismatch` → 0.
  - All program slots → 0.
  - Step counter → 0.

## Timing
- `start` accepted at edge k.
- RUN spans cycles k+1 .. k+n; step i is driven in cycle k+1+i.
- `done` is high in cycle k+n+1.
- IDLE begins at k+n+2; a new `start` can be accepted at edge k+n+2.
- Throughput: n+2 cycles per run.
- `a_in` must settle within the same cycle as `g_out`/`x_out`; there is no extra pipeline stage.

## Configuration
- Macro `BBLOCK_SEQ_CHECK_EN`.
- **Defined:** an internal model computes the expected A from the registered outputs:
  - expected = (~(g4|g5|g1) & g2) | (~g3 & x) | (g3 & g1)
  - Each RUN cycle, expected is compared with `a_in`.
  - Any difference sets `mismatch` on that edge.
  - `mismatch` is sticky until the next accepted `start` or reset.
- **Undefined:** the model is not built and `mismatch` is tied to 0.

## Test plan
- **Basic run.** Load slots 0..3 = 0x02, 0x05, 0x04, 0x20; `len`=4; pulse `start`. Required:
  - `busy` high for cycles k+1..k+4; `done` only at k+5.
  - `result[3:0]`=4'b1011.
- **Output ordering.** `len`=9 with DEPTH=8 runs 8 steps; `len`=0 leaves the block in IDLE with no `done`.
- **Ignored inputs during RUN.** `start` and `prog_we` (slot 1 = 0x00) during RUN have no effect: the run completes normally and a rerun still gives `result[1]`=1.
- **Reset mid-run.** Assert `rst_n`=0 during step 2. Required:
  - All outputs 0 asynchronously.
  - After release, a run of `len`=1 on slot 0 (now 0x00) gives `result[0]`=0.
- **Checker.** With `BBLOCK_SEQ_CHECK_EN` defined, force `a_in`=0 on slot code 0x38. Required:
  - `mismatch`=1 by `done`.
  - `mismatch` cleared on the next `start`.
  - Without the macro, `mismatch` stays 0.
- **Back-to-back runs.** `start` held high continuously: runs are accepted every n+2 cycles, with `done` pulses spaced n+2 apart.

Source files
------------

// File: rtl/bblock_seq_if.sv
// bblock_seq_if: host/program port and B-block cell port
// of the B-block sequencer.
interface bblock_seq_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
);
  logic             prog_we;
  logic [AW-1:0]    prog_addr;
  logic [5:0]       prog_data;
  logic [AW:0]      len;
  logic             start;
  logic             busy;
  logic             done;
  logic [4:0]       g_out;
  logic             x_out;
  logic             a_in;
  logic [DEPTH-1:0] result;
  logic             mismatch;

  modport slave (
    input  prog_we, prog_addr, prog_data,
    input  len, start, a_in,
    output busy, done, g_out, x_out,
    output result, mismatch
  );

  modport master (
    output prog_we, prog_addr, prog_data,
    output len, start, a_in,
    input  busy, done, g_out, x_out,
    input  result, mismatch
  );
endinterface

// File: rtl/bblock_seq.sv
// bblock_seq: plays programmed {x,g5..g1} codes into a B-block
// cell and captures A per step; BBLOCK_SEQ_CHECK_EN adds a checker.
module bblock_seq #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic         clk,
  input logic         rst_n,
  bblock_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t           state_q;
  logic [5:0]       mem_q [DEPTH];
  logic [AW-1:0]    step_q;
  logic [AW-1:0]    step_d;
  logic [AW:0]      n_q;
  logic [AW:0]      n_d;
  logic [DEPTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic [4:0]       g_q;
  logic             x_q;
  logic [5:0]       code0_d;
  logic [5:0]       next_d;
  logic             accept_d;
  logic             last_d;

  assign n_d = (bus.len > DEPTH_W) ? DEPTH_W : bus.len;

  assign accept_d = (state_q == IDLE)
                  && bus.start
                  && (bus.len != '0);

  // a write landing on the accept edge must reach slot 0 now
  assign code0_d = (bus.prog_we && bus.prog_addr == '0)
                 ? bus.prog_data : mem_q[0];

  assign step_d = step_q + 1'b1;
  assign next_d = mem_q[step_d];
  assign last_d = ({1'b0, step_q} == (n_q - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      n_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      g_q      <= '0;
      x_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.prog_we) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
          end
          if (accept_d) begin
            state_q    <= RUN;
            step_q     <= '0;
            n_q        <= n_d;
            result_q   <= '0;
            busy_q     <= 1'b1;
            {x_q, g_q} <= code0_d;
          end
        end
        RUN: begin
          result_q[step_q] <= bus.a_in;
          step_q           <= step_d;
          if (last_d) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            {x_q, g_q} <= '0;
          end else begin
            {x_q, g_q} <= next_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef BBLOCK_SEQ_CHECK_EN
  logic mismatch_q;
  logic exp_a;

  assign exp_a = (~(g_q[3] | g_q[4] | g_q[0]) & g_q[1])
               | (~g_q[2] & x_q)
               | (g_q[2] & g_q[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else if (accept_d) begin
      mismatch_q <= 1'b0;
    end else if (state_q == RUN && exp_a != bus.a_in) begin
      mismatch_q <= 1'b1;
    end
  end

  assign bus.mismatch = mismatch_q;
`else
  assign bus.mismatch = 1'b0;
`endif

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.g_out  = g_q;
  assign bus.x_out  = x_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_bblock_seq.sv
// tb_bblock_seq: table-driven and directed checks of the
// B-block sequencer against a behavioural B-block cell.
module tb_bblock_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic force_a0 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bblock_seq_if #(.DEPTH(8), .AW(3)) bif ();

  bblock_seq #(.DEPTH(8), .AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  // behavioural B-block cell
  assign bif.a_in = force_a0 ? 1'b0 :
      ((~(bif.g_out[3] | bif.g_out[4] | bif.g_out[0])
        & bif.g_out[1])
       | (~bif.g_out[2] & bif.x_out)
       | (bif.g_out[2] & bif.g_out[0]));

  typedef struct {
    int         l;
    int         nb;
    int         doff;
    logic [5:0] c1;
    logic [7:0] res;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [5:0] d);
    bif.prog_we   = 1'b1;
    bif.prog_addr = a[2:0];
    bif.prog_data = d;
    tick();
    bif.prog_we   = 1'b0;
  endtask

  task automatic run(input int l, input bit disturb,
                     output int nb, output int doff,
                     output int nd, output logic [5:0] c1,
                     output logic [7:0] res,
                     output logic mm);
    nb   = 0;
    doff = -1;
    nd   = 0;
    c1   = '0;
    bif.start = 1'b1;
    bif.len   = l[3:0];
    tick();
    bif.start = 1'b0;
    for (int off = 1; off <= 14; off++) begin
      if (off == 1) c1 = {bif.x_out, bif.g_out};
      if (bif.busy) nb++;
      if (bif.done) begin
        nd++;
        if (doff < 0) doff = off;
      end
      if (disturb && off == 2) begin
        bif.start     = 1'b1;
        bif.prog_we   = 1'b1;
        bif.prog_addr = 3'd1;
        bif.prog_data = 6'h00;
      end else begin
        bif.start   = 1'b0;
        bif.prog_we = 1'b0;
      end
      tick();
    end
    res = bif.result;
    mm  = bif.mismatch;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int nb, doff, nd, first, second, cnt;
    logic [5:0] c1;
    logic [7:0] res;
    logic mm;
    logic exp_mm;

    bif.prog_we   = 1'b0;
    bif.prog_addr = '0;
    bif.prog_data = '0;
    bif.len       = '0;
    bif.start     = 1'b0;

    tbl[0] = '{4,  4, 5,  6'h02, 8'h0B};
    tbl[1] = '{9,  8, 9,  6'h02, 8'h9B};
    tbl[2] = '{1,  1, 2,  6'h02, 8'h01};
    tbl[3] = '{0,  0, -1, 6'h00, 8'h01};
    tbl[4] = '{15, 8, 9,  6'h02, 8'h9B};
    tbl[5] = '{5,  5, 6,  6'h02, 8'h1B};
    tbl[6] = '{2,  2, 3,  6'h02, 8'h03};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_g", bif.g_out, 0);
    chk("rst_x", bif.x_out, 0);
    chk("rst_result", bif.result, 0);
    chk("rst_mismatch", bif.mismatch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    wr(0, 6'h02); wr(1, 6'h05);
    wr(2, 6'h04); wr(3, 6'h20);
    wr(4, 6'h38); wr(5, 6'h00);
    wr(6, 6'h01); wr(7, 6'h06);

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].l, 1'b0, nb, doff, nd, c1, res, mm);
      chk($sformatf("v%0d_busy", i), nb, tbl[i].nb);
      chk($sformatf("v%0d_done_at", i), doff, tbl[i].doff);
      chk($sformatf("v%0d_ndone", i), nd,
          (tbl[i].l == 0) ? 0 : 1);
      chk($sformatf("v%0d_code0", i), c1, tbl[i].c1);
      chk($sformatf("v%0d_result", i), res, tbl[i].res);
      chk($sformatf("v%0d_mismatch", i), mm, 0);
    end

    run(4, 1'b1, nb, doff, nd, c1, res, mm);
    chk("dist_busy", nb, 4);
    chk("dist_done_at", doff, 5);
    chk("dist_ndone", nd, 1);
    chk("dist_result", res, 8'h0B);
    run(4, 1'b0, nb, doff, nd, c1, res, mm);
    chk("dist_rerun", res, 8'h0B);

`ifdef BBLOCK_SEQ_CHECK_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    wr(0, 6'h38);
    force_a0 = 1'b1;
    run(1, 1'b0, nb, doff, nd, c1, res, mm);
    force_a0 = 1'b0;
    chk("chk_mismatch", mm, exp_mm);
    chk("chk_result", res, 8'h00);
    bif.start = 1'b1;
    bif.len   = 4'd1;
    tick();
    bif.start = 1'b0;
    chk("chk_cleared", bif.mismatch, 0);
    repeat (4) tick();

    wr(0, 6'h02);
    bif.start = 1'b1;
    bif.len   = 4'd4;
    tick();
    bif.start = 1'b0;
    tick();
    tick();
    chk("mid_code2", {bif.x_out, bif.g_out}, 6'h04);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy", bif.busy, 0);
    chk("mid_done", bif.done, 0);
    chk("mid_g", bif.g_out, 0);
    chk("mid_x", bif.x_out, 0);
    chk("mid_result", bif.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run(1, 1'b0, nb, doff, nd, c1, res, mm);
    chk("post_rst_r0", res, 8'h00);
    chk("post_rst_done", doff, 2);
    run(4, 1'b0, nb, doff, nd, c1, res, mm);
    chk("post_rst_r4", res, 8'h00);

    bif.prog_we   = 1'b1;
    bif.prog_addr = 3'd0;
    bif.prog_data = 6'h02;
    bif.start     = 1'b1;
    bif.len       = 4'd1;
    tick();
    bif.prog_we = 1'b0;
    bif.start   = 1'b0;
    chk("simul_code", {bif.x_out, bif.g_out}, 6'h02);
    repeat (4) tick();
    chk("simul_result", bif.result, 8'h01);

    wr(1, 6'h05);
    first  = -1;
    second = -1;
    cnt    = 0;
    bif.start = 1'b1;
    bif.len   = 4'd2;
    tick();
    for (int off = 1; off <= 12; off++) begin
      if (bif.done) begin
        cnt++;
        if (first < 0) first = off;
        else if (second < 0) second = off;
      end
      tick();
    end
    bif.start = 1'b0;
    repeat (6) tick();
    chk("b2b_first", first, 3);
    chk("b2b_spacing", second - first, 4);
    chk("b2b_count", cnt, 3);
    chk("b2b_result", bif.result, 8'h03);
    chk("b2b_idle", bif.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
